// File: rtl/div_host_link.sv
// ============================================================================
// Module  : div_host_link
// Brief   : Host-side initiator for the byte-stream divider protocol. It sends
//           the dividend and divisor as four bytes, then collects the four
//           response bytes and rebuilds the quotient and remainder.
//           Optional macro DIVZERO_CHECK_EN rejects divisor==0 locally.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_host_link #(
    parameter int BYTE_GAP     = 16,
    parameter int RESP_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);

    localparam int GAP_W = $clog2(BYTE_GAP + 1);
    localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t             r_state,   w_state_n;
    logic [1:0]         r_idx,     w_idx_n;
    logic [GAP_W-1:0]   r_gap,     w_gap_n;
    logic [TO_W-1:0]    r_tcnt,    w_tcnt_n;
    logic [1:0]         r_rcnt,    w_rcnt_n;
    logic [31:0]        r_asm,     w_asm_n;
    logic [15:0]        r_dvd,     w_dvd_n;
    logic [15:0]        r_dvs,     w_dvs_n;
    logic [15:0]        r_quo,     w_quo_n;
    logic [15:0]        r_rem,     w_rem_n;
    logic [7:0]         r_tx_hold, w_tx_hold_n;
    logic               r_done,    w_done_n;
    logic               r_err,     w_err_n;
`ifdef DIVZERO_CHECK_EN
    logic               r_dz,      w_dz_n;
`endif

    logic               w_strobe;
    logic [7:0]         w_tx_cur;

    always_comb begin
        w_tx_cur = r_dvd[15:8];
        case (r_idx)
            2'd0:    w_tx_cur = r_dvd[15:8];
            2'd1:    w_tx_cur = r_dvd[7:0];
            2'd2:    w_tx_cur = r_dvs[15:8];
            default: w_tx_cur = r_dvs[7:0];
        endcase
    end

    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_gap_n     = r_gap;
        w_tcnt_n    = r_tcnt;
        w_rcnt_n    = r_rcnt;
        w_asm_n     = r_asm;
        w_dvd_n     = r_dvd;
        w_dvs_n     = r_dvs;
        w_quo_n     = r_quo;
        w_rem_n     = r_rem;
        w_tx_hold_n = r_tx_hold;
        w_done_n    = 1'b0;
        w_err_n     = 1'b0;
        w_strobe    = 1'b0;
`ifdef DIVZERO_CHECK_EN
        w_dz_n      = r_dz;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dvd_n   = dividend;
                    w_dvs_n   = divisor;
                    w_idx_n   = 2'd0;
                    w_gap_n   = '0;
                    w_state_n = S_SEND;
`ifdef DIVZERO_CHECK_EN
                    // FINISH is reused as the single busy cycle of a rejection.
                    w_dz_n = 1'b0;
                    if (divisor == 16'h0000) begin
                        w_state_n = S_FINISH;
                        w_dz_n    = 1'b1;
                        w_err_n   = 1'b1;
                        w_quo_n   = 16'hFFFF;
                        w_rem_n   = dividend;
                    end
`endif
                end
            end
            S_SEND: begin
                if (r_gap == '0) begin
                    w_strobe    = 1'b1;
                    w_tx_hold_n = w_tx_cur;
                    if (r_idx == 2'd3) begin
                        w_state_n = S_WAIT_RESP;
                        w_tcnt_n  = '0;
                        w_rcnt_n  = 2'd0;
                    end else begin
                        w_idx_n = r_idx + 2'd1;
                        w_gap_n = GAP_W'(BYTE_GAP);
                    end
                end else begin
                    w_gap_n = r_gap - 1'b1;
                end
            end
            S_WAIT_RESP: begin
                // A byte arriving on the terminal-count cycle takes priority.
                if (rx_valid) begin
                    w_asm_n  = {r_asm[23:0], rx_byte};
                    w_tcnt_n = '0;
                    w_rcnt_n = r_rcnt + 2'd1;
                    if (r_rcnt == 2'd3) begin
                        w_state_n = S_FINISH;
                    end
                end else if (r_tcnt == TO_W'(RESP_TIMEOUT - 1)) begin
                    w_tcnt_n  = '0;
                    w_err_n   = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_tcnt_n = r_tcnt + 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
`ifdef DIVZERO_CHECK_EN
                if (r_dz) begin
                    w_dz_n = 1'b0;
                end else begin
                    w_quo_n  = r_asm[31:16];
                    w_rem_n  = r_asm[15:0];
                    w_done_n = 1'b1;
                end
`else
                w_quo_n  = r_asm[31:16];
                w_rem_n  = r_asm[15:0];
                w_done_n = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_gap     <= '0;
            r_tcnt    <= '0;
            r_rcnt    <= 2'd0;
            r_asm     <= 32'h0;
            r_dvd     <= 16'h0;
            r_dvs     <= 16'h0;
            r_quo     <= 16'h0;
            r_rem     <= 16'h0;
            r_tx_hold <= 8'h0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef DIVZERO_CHECK_EN
            r_dz      <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_gap     <= w_gap_n;
            r_tcnt    <= w_tcnt_n;
            r_rcnt    <= w_rcnt_n;
            r_asm     <= w_asm_n;
            r_dvd     <= w_dvd_n;
            r_dvs     <= w_dvs_n;
            r_quo     <= w_quo_n;
            r_rem     <= w_rem_n;
            r_tx_hold <= w_tx_hold_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
`ifdef DIVZERO_CHECK_EN
            r_dz      <= w_dz_n;
`endif
        end
    end

    // The byte is presented live on its strobe cycle and held afterwards.
    assign tx_valid  = w_strobe;
    assign tx_byte   = w_strobe ? w_tx_cur : r_tx_hold;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_div_host_link.sv
// ============================================================================
// Module  : tb_div_host_link
// Brief   : Directed self-checking bench for div_host_link (honours the
//           optional DIVZERO_CHECK_EN macro).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_host_link;

    localparam int BG = 4;
    localparam int RT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = 16'h0;
    logic [15:0] divisor = 16'h0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h0;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] quotient;
    logic [15:0] remainder;

    div_host_link #(.BYTE_GAP(BG), .RESP_TIMEOUT(RT)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .busy(busy), .done(done), .err(err), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       n_tx = 0;
    logic [7:0] tx_b [0:63];
    int       tx_cyc [0:63];
    int       done_cnt = 0;
    int       done_cyc = 0;
    logic     done_busy = 1'b0;
    int       err_cnt = 0;
    int       err_cyc = 0;

    always @(negedge clk) begin
        if (tx_valid && n_tx < 64) begin
            tx_b[n_tx]   = tx_byte;
            tx_cyc[n_tx] = cyc;
            n_tx         = n_tx + 1;
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] dvd, input logic [15:0] dvs, output int acc);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        acc      = cyc;
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 200 && n_tx < target; i++) tick();
        check("tx_count", n_tx, target);
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 200 && done_cnt <= base; i++) tick();
        check("done_seen", done_cnt, base + 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap, output int rcyc);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_byte  = b;
        rcyc     = cyc;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_tx(input int base, input logic [31:0] exp, input int acc);
        check("tx_first_cycle", tx_cyc[base], acc);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            e = exp >> (8 * (3 - k));
            check($sformatf("tx_byte%0d", k), tx_b[base + k], {24'h0, e[7:0]});
            if (k > 0)
                check($sformatf("tx_gap%0d", k), tx_cyc[base + k] - tx_cyc[base + k - 1], BG + 1);
        end
    endtask

    initial begin
        int acc, rc, base, base2, d0, e0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_txb", tx_byte, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_quo", quotient, 0);
        check("rst_rem", remainder, 0);
        rst = 1'b0;
        tick();

        // 115 / 10
        base = n_tx;
        do_start(16'd115, 16'd10, acc);
        check("first_strobe_now", tx_valid, 1);
        check("busy_send", busy, 1);
        wait_tx(base + 4);
        check_tx(base, 32'h0073_000A, acc);
        d0 = done_cnt;
        e0 = err_cnt;
        send_rx(8'h00, 2, rc);
        send_rx(8'h0B, 0, rc);
        send_rx(8'h00, 3, rc);
        send_rx(8'h05, 1, rc);
        wait_done(d0);
        check("done_latency", done_cyc, rc + 2);
        check("done_busy_low", done_busy, 0);
        check("quo_11", quotient, 16'd11);
        check("rem_5", remainder, 16'd5);
        check("no_err_t1", err_cnt, e0);

        // start during SEND is ignored, then the missing reply times out
        base = n_tx;
        do_start(16'h0102, 16'h0304, acc);
        tick();
        tick();
        dividend = 16'hDEAD;
        divisor  = 16'hBEEF;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_tx(base + 4);
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (15) tick();
        check("only_four_strobes", n_tx, base + 4);
        check_tx(base, 32'h0102_0304, acc);
        for (int i = 0; i < 100 && err_cnt == e0; i++) tick();
        check("timeout_err", err_cnt, e0 + 1);
        check("timeout_cycle", err_cyc, tx_cyc[base + 3] + 1 + RT);
        check("timeout_no_done", done_cnt, d0);
        tick();
        check("timeout_busy_low", busy, 0);
        check("timeout_quo_kept", quotient, 16'd11);
        check("timeout_rem_kept", remainder, 16'd5);

        // reset after the second strobe, then a clean restart
        base = n_tx;
        do_start(16'h1122, 16'h3344, acc);
        wait_tx(base + 2);
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_txv", tx_valid, 0);
        check("midrst_quo", quotient, 0);
        check("midrst_rem", remainder, 0);
        rst = 1'b0;
        tick();
        check("midrst_no_extra", n_tx, base + 2);
        base2 = n_tx;
        do_start(16'h1122, 16'h3344, acc);
        wait_tx(base2 + 4);
        check_tx(base2, 32'h1122_3344, acc);
        d0 = done_cnt;
        send_rx(8'h00, 1, rc);
        send_rx(8'h00, 1, rc);
        send_rx(8'h11, 1, rc);
        send_rx(8'h22, 1, rc);
        wait_done(d0);
        check("restart_quo", quotient, 16'h0000);
        check("restart_rem", remainder, 16'h1122);

        // slow reply, 30 cycles per byte, stays inside the timeout
        base = n_tx;
        e0 = err_cnt;
        d0 = done_cnt;
        do_start(16'hFFFF, 16'h0001, acc);
        wait_tx(base + 4);
        check_tx(base, 32'hFFFF_0001, acc);
        send_rx(8'hFF, 30, rc);
        send_rx(8'hFF, 30, rc);
        send_rx(8'h00, 30, rc);
        send_rx(8'h00, 30, rc);
        wait_done(d0);
        check("slow_no_err", err_cnt, e0);
        check("slow_quo", quotient, 16'hFFFF);
        check("slow_rem", remainder, 16'h0000);

`ifdef DIVZERO_CHECK_EN
        base = n_tx;
        d0 = done_cnt;
        do_start(16'h1234, 16'h0000, acc);
        check("dz_err", err, 1);
        check("dz_busy", busy, 1);
        check("dz_txv", tx_valid, 0);
        check("dz_quo", quotient, 16'hFFFF);
        check("dz_rem", remainder, 16'h1234);
        tick();
        check("dz_busy_low", busy, 0);
        check("dz_err_low", err, 0);
        repeat (20) tick();
        check("dz_no_strobes", n_tx, base);
        check("dz_no_done", done_cnt, d0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
